// File: rtl/pipe_ifetch.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ifetch
//  Brief    : Instruction-fetch controller. Drives the PC register, runs a
//             single-outstanding fetch to instruction memory and buffers
//             returned words in a small FIFO for the decode stage.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_ifetch #(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] npc,
  output logic        wpcir,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc4,
  input  logic        id_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] C_DEPTH = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          pend_v_q, pend_v_d;
  logic [31:0]   pend_pc_q, pend_pc_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [31:0]   fifo_inst_q [DEPTH];
  logic [31:0]   fifo_inst_d [DEPTH];
  logic [31:0]   fifo_addr_q [DEPTH];
  logic [31:0]   fifo_addr_d [DEPTH];

  logic [31:0]   fa;
  logic [PW:0]   count_eff;
  logic          issue;
  logic          push;
  logic          pop;

  assign fa        = redirect ? redirect_pc : (pend_v_q ? pend_pc_q : pc + 32'd4);
  // A redirect empties the FIFO this cycle, so it always leaves room to issue.
  assign count_eff = redirect ? '0 : count_q;

  always_comb begin
    state_d    = state_q;
    pend_v_d   = pend_v_q;
    pend_pc_d  = pend_pc_q;
    req_addr_d = req_addr_q;
    issue      = 1'b0;
    push       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_eff < C_DEPTH) begin
          issue      = 1'b1;
          req_addr_d = fa;
          pend_v_d   = 1'b0;
          state_d    = S_WAIT;
        end else if (redirect) begin
          pend_pc_d = redirect_pc;
          pend_v_d  = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          push    = !redirect;
          state_d = S_IDLE;
        end
        if (redirect) begin
          pend_pc_d = redirect_pc;
          pend_v_d  = 1'b1;
          if (!imem_ack) state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (redirect) begin
          pend_pc_d = redirect_pc;
          pend_v_d  = 1'b1;
        end
        if (imem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pop = (count_q != '0) && id_ready && !redirect;

  always_comb begin
    fifo_inst_d = fifo_inst_q;
    fifo_addr_d = fifo_addr_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        fifo_inst_d[wr_ptr_q] = imem_rdata;
        fifo_addr_d[wr_ptr_q] = req_addr_q;
        wr_ptr_d              = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pend_v_q   <= 1'b0;
      pend_pc_q  <= '0;
      req_addr_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pend_v_q   <= pend_v_d;
      pend_pc_q  <= pend_pc_d;
      req_addr_q <= req_addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage is qualified by count, so it needs no reset.
  always_ff @(posedge clock) begin
    fifo_inst_q <= fifo_inst_d;
    fifo_addr_q <= fifo_addr_d;
  end

  assign imem_req  = issue && !reset;
  assign wpcir     = issue && !reset;
  assign imem_addr = fa;
  assign npc       = fa;
  assign if_valid  = (count_q != '0);
  assign if_inst   = fifo_inst_q[rd_ptr_q];
  assign if_pc4    = fifo_addr_q[rd_ptr_q] + 32'd4;

endmodule
`default_nettype wire
